// File: rtl/cmac_tx_gate_if.sv
// rtl/cmac_tx_gate_if.sv - AXI-Stream style bundle shared by the user and CMAC sides of the tx gate
// The slave view omits tuser because the user stream carries no error marking.
interface cmac_tx_gate_if #(
  parameter int DATA_W = 512
);
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic                tlast;
  logic                tuser;
  logic                tvalid;
  logic                tready;

  modport master (output tdata, tkeep, tlast, tuser, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/cmac_tx_gate.sv
// rtl/cmac_tx_gate.sv - packet-aware gate in front of CMAC axis_tx, driven by PCS alignment
// Forwards whole packets only while alignment is stable; a mid-packet loss closes the frame with an error beat.
module cmac_tx_gate #(
  parameter int DATA_W         = 512,
  parameter int SYNC_FF        = 3,
  parameter int LINK_SETTLE    = 1024,
  parameter int DROP_WHEN_DOWN = 1
) (
  input  logic                  i_tx_clk,
  input  logic                  i_tx_reset_in,
  input  logic                  i_link_aligned,
  cmac_tx_gate_if.slave         s_axis,
  cmac_tx_gate_if.master        m_axis,
  output logic                  o_link_ready,
  output logic [31:0]           o_pkt_sent_count,
  output logic [31:0]           o_pkt_abort_count,
  output logic [31:0]           o_pkt_drop_count
);

  localparam int KEEP_W = DATA_W / 8;
  localparam int CNT_W  = (LINK_SETTLE < 2) ? 1 : $clog2(LINK_SETTLE + 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(LINK_SETTLE);
  localparam logic DROP_RDY = (DROP_WHEN_DOWN != 0);

  typedef enum logic [2:0] {
    ST_DOWN, ST_SETTLE, ST_IDLE, ST_PKT, ST_ABORT, ST_DISCARD
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [SYNC_FF-1:0]  r_sync;
  logic [CNT_W-1:0]    r_settle;
  logic                r_in_pkt;
  logic [DATA_W-1:0]   r_m_tdata;
  logic [KEEP_W-1:0]   r_m_tkeep;
  logic                r_m_tlast, r_m_tuser, r_m_tvalid;
  logic [31:0]         r_sent, r_abort, r_drop;

  logic w_sl, w_slot_free, w_s_tready, w_accept, w_in_pkt_nxt;
  logic w_fwd, w_abort_load, w_settle_load, w_discard;

  assign w_sl         = r_sync[SYNC_FF-1];
  assign w_slot_free  = !r_m_tvalid || m_axis.tready;
  assign w_accept     = s_axis.tvalid && w_s_tready;
  assign w_in_pkt_nxt = w_accept ? !s_axis.tlast : r_in_pkt;

  always_ff @(posedge i_tx_clk or posedge i_tx_reset_in) begin
    if (i_tx_reset_in) r_sync <= '0;
    else               r_sync <= {r_sync[SYNC_FF-2:0], i_link_aligned};
  end

  // Ready is held low through reset so nothing is accepted before DOWN is established.
  always_comb begin
    w_s_tready = 1'b0;
    if (!i_tx_reset_in) begin
      case (r_state)
        ST_DOWN, ST_SETTLE: w_s_tready = DROP_RDY;
        ST_IDLE, ST_PKT:    w_s_tready = w_sl && w_slot_free;
        ST_DISCARD:         w_s_tready = 1'b1;
        default:            w_s_tready = 1'b0;
      endcase
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_fwd         = 1'b0;
    w_abort_load  = 1'b0;
    w_settle_load = 1'b0;
    w_discard     = 1'b0;
    case (r_state)
      ST_DOWN: begin
        w_discard = 1'b1;
        if (w_sl) begin
          w_state_nxt   = ST_SETTLE;
          w_settle_load = 1'b1;
        end
      end
      ST_SETTLE: begin
        w_discard = 1'b1;
        if (!w_sl) w_state_nxt = ST_DOWN;
        else if (r_settle == '0 && !w_in_pkt_nxt) w_state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (!w_sl) w_state_nxt = ST_DOWN;
        else if (w_accept) begin
          w_fwd = 1'b1;
          if (!s_axis.tlast) w_state_nxt = ST_PKT;
        end
      end
      ST_PKT: begin
        if (!w_sl) w_state_nxt = ST_ABORT;
        else if (w_accept) begin
          w_fwd = 1'b1;
          if (s_axis.tlast) w_state_nxt = ST_IDLE;
        end
      end
      ST_ABORT: begin
        if (w_slot_free) begin
          w_abort_load = 1'b1;
          w_state_nxt  = ST_DISCARD;
        end
      end
      ST_DISCARD: begin
        w_discard = 1'b1;
        if (w_accept && s_axis.tlast) w_state_nxt = ST_DOWN;
      end
      default: w_state_nxt = ST_DOWN;
    endcase
  end

  always_ff @(posedge i_tx_clk or posedge i_tx_reset_in) begin
    if (i_tx_reset_in) begin
      r_state  <= ST_DOWN;
      r_settle <= '0;
      r_in_pkt <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_in_pkt <= w_in_pkt_nxt;
      if (w_settle_load) r_settle <= SETTLE_LOAD;
      else if (r_state == ST_SETTLE && w_sl && r_settle != '0) r_settle <= r_settle - 1'b1;
    end
  end

  // Output register only changes on a load or a completed handshake, so it holds steady while stalled.
  always_ff @(posedge i_tx_clk or posedge i_tx_reset_in) begin
    if (i_tx_reset_in) begin
      r_m_tdata  <= '0;
      r_m_tkeep  <= '0;
      r_m_tlast  <= 1'b0;
      r_m_tuser  <= 1'b0;
      r_m_tvalid <= 1'b0;
    end else if (w_fwd) begin
      r_m_tdata  <= s_axis.tdata;
      r_m_tkeep  <= s_axis.tkeep;
      r_m_tlast  <= s_axis.tlast;
      r_m_tuser  <= 1'b0;
      r_m_tvalid <= 1'b1;
    end else if (w_abort_load) begin
      r_m_tdata  <= '0;
      r_m_tkeep  <= '1;
      r_m_tlast  <= 1'b1;
      r_m_tuser  <= 1'b1;
      r_m_tvalid <= 1'b1;
    end else if (m_axis.tready) begin
      r_m_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge i_tx_clk or posedge i_tx_reset_in) begin
    if (i_tx_reset_in) begin
      r_sent  <= '0;
      r_abort <= '0;
      r_drop  <= '0;
    end else begin
      if (r_m_tvalid && m_axis.tready && r_m_tlast && !r_m_tuser) r_sent <= r_sent + 32'd1;
      if (w_abort_load) r_abort <= r_abort + 32'd1;
      if (w_accept && s_axis.tlast && w_discard) r_drop <= r_drop + 32'd1;
    end
  end

  assign s_axis.tready     = w_s_tready;
  assign m_axis.tdata      = r_m_tdata;
  assign m_axis.tkeep      = r_m_tkeep;
  assign m_axis.tlast      = r_m_tlast;
  assign m_axis.tuser      = r_m_tuser;
  assign m_axis.tvalid     = r_m_tvalid;
  assign o_link_ready      = (r_state == ST_IDLE) || (r_state == ST_PKT);
  assign o_pkt_sent_count  = r_sent;
  assign o_pkt_abort_count = r_abort;
  assign o_pkt_drop_count  = r_drop;

endmodule

// File: tb/tb_cmac_tx_gate.sv
// tb/tb_cmac_tx_gate.sv - self-checking bench for cmac_tx_gate with an output scoreboard
// Beats expected on m_axis are queued as input is accepted and popped when the DUT hands them off.
module tb_cmac_tx_gate;
  localparam int DW = 64;
  localparam int KW = DW / 8;
  localparam int SFF = 3;
  localparam int SETTLE = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic link = 1'b0;
  logic link2 = 1'b0;
  always #5 clk = ~clk;

  cmac_tx_gate_if #(.DATA_W(DW)) s_if ();
  cmac_tx_gate_if #(.DATA_W(DW)) m_if ();
  cmac_tx_gate_if #(.DATA_W(DW)) s2_if ();
  cmac_tx_gate_if #(.DATA_W(DW)) m2_if ();

  logic        lr, lr2;
  logic [31:0] sent, abrt, drop, sent2, abrt2, drop2;

  cmac_tx_gate #(.DATA_W(DW), .SYNC_FF(SFF), .LINK_SETTLE(SETTLE), .DROP_WHEN_DOWN(1)) dut (
    .i_tx_clk(clk), .i_tx_reset_in(rst), .i_link_aligned(link),
    .s_axis(s_if), .m_axis(m_if), .o_link_ready(lr),
    .o_pkt_sent_count(sent), .o_pkt_abort_count(abrt), .o_pkt_drop_count(drop));

  cmac_tx_gate #(.DATA_W(DW), .SYNC_FF(SFF), .LINK_SETTLE(SETTLE), .DROP_WHEN_DOWN(0)) dut2 (
    .i_tx_clk(clk), .i_tx_reset_in(rst), .i_link_aligned(link2),
    .s_axis(s2_if), .m_axis(m2_if), .o_link_ready(lr2),
    .o_pkt_sent_count(sent2), .o_pkt_abort_count(abrt2), .o_pkt_drop_count(drop2));

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    logic          u;
  } beat_t;

  typedef struct {
    int          beats;
    logic [63:0] base;
    logic [7:0]  last_keep;
    int          exp_sent;
  } vec_t;

  beat_t exp_q[$];
  int    total = 0;
  int    bad = 0;
  int    sent_exp = 0, abort_exp = 0, drop_exp = 0;
  bit    rnd_ready = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  logic  stall = 1'b0;
  beat_t stall_b;
  beat_t want_b;
  always @(negedge clk) begin
    if (rst) stall = 1'b0;
    else begin
      if (stall) begin
        total++;
        if (m_if.tvalid !== 1'b1 || m_if.tdata !== stall_b.d || m_if.tkeep !== stall_b.k ||
            m_if.tlast !== stall_b.l || m_if.tuser !== stall_b.u) begin
          bad++;
          $display("FAIL stall_hold: tvalid=%0b tdata=%0h want held tdata=%0h", m_if.tvalid, m_if.tdata, stall_b.d);
        end
      end
      if (m_if.tvalid && m_if.tready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL out_beat: unexpected tdata=%0h tlast=%0b tuser=%0b", m_if.tdata, m_if.tlast, m_if.tuser);
        end else begin
          want_b = exp_q.pop_front();
          if (m_if.tdata !== want_b.d || m_if.tkeep !== want_b.k || m_if.tlast !== want_b.l || m_if.tuser !== want_b.u) begin
            bad++;
            $display("FAIL out_beat: got d=%0h k=%0h l=%0b u=%0b want d=%0h k=%0h l=%0b u=%0b",
                     m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tuser, want_b.d, want_b.k, want_b.l, want_b.u);
          end
        end
      end
      stall = m_if.tvalid && !m_if.tready;
      stall_b.d = m_if.tdata;
      stall_b.k = m_if.tkeep;
      stall_b.l = m_if.tlast;
      stall_b.u = m_if.tuser;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd_ready) m_if.tready = ($urandom_range(0, 1) == 1);
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
    bit ok = 1'b0;
    s_if.tdata  = d;
    s_if.tkeep  = k;
    s_if.tlast  = l;
    s_if.tvalid = 1'b1;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (s_if.tready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    s_if.tvalid = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_timeout: tready stayed %0b want 1", s_if.tready);
    end
  endtask

  task automatic send_range(input int n, input int from, input int to, input logic [63:0] base,
                            input logic [7:0] lk, input bit fwd);
    beat_t b;
    for (int i = from; i < to; i++) begin
      b.d = base + 64'(i);
      b.l = (i == n - 1);
      b.k = b.l ? lk : 8'hFF;
      b.u = 1'b0;
      send_beat(b.d, b.k, b.l);
      if (fwd) exp_q.push_back(b);
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 4000 && (exp_q.size() != 0 || m_if.tvalid); i++) cyc(1);
    cyc(1);
    chk("drain_queue", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!lr && n < 200) begin
      cyc(1);
      n++;
    end
    chk(name, 64'(n), 64'(SFF + 18));
  endtask

  initial begin
    vec_t  tbl[4];
    beat_t ab;
    tbl[0] = '{4, 64'h1111_0000_0000_0000, 8'hFF, 1};
    tbl[1] = '{1, 64'h2222_0000_0000_0100, 8'h01, 2};
    tbl[2] = '{7, 64'h3333_0000_0000_0200, 8'h0F, 3};
    tbl[3] = '{2, 64'h4444_0000_0000_0300, 8'h80, 4};

    s_if.tdata = '0; s_if.tkeep = '0; s_if.tlast = 1'b0; s_if.tvalid = 1'b0; s_if.tuser = 1'b0;
    m_if.tready = 1'b1;
    s2_if.tdata = '0; s2_if.tkeep = '1; s2_if.tlast = 1'b1; s2_if.tvalid = 1'b1; s2_if.tuser = 1'b0;
    m2_if.tready = 1'b1;

    cyc(3);
    chk("rst_tvalid", 64'(m_if.tvalid), 0);
    chk("rst_tdata", m_if.tdata, 0);
    chk("rst_tuser", 64'(m_if.tuser), 0);
    chk("rst_tready", 64'(s_if.tready), 0);
    chk("rst_link_ready", 64'(lr), 0);
    chk("rst_counts", {sent[15:0], abrt[15:0], drop[15:0], 16'd0}, 0);
    rst = 1'b0;
    cyc(1);
    chk("down_tready_drop", 64'(s_if.tready), 1);

    for (int p = 0; p < 5; p++) begin
      send_range(p + 1, 0, p + 1, 64'hDEAD_0000 + 64'(p * 16), 8'hFF, 1'b0);
      drop_exp++;
      chk("nodrop_tready", 64'(s2_if.tready), 0);
      chk("nodrop_tvalid", 64'(m2_if.tvalid), 0);
    end
    cyc(2);
    chk("down_drop_count", 64'(drop), 64'(drop_exp));
    chk("down_no_tvalid", 64'(m_if.tvalid), 0);

    link = 1'b1;
    wait_ready("bringup_latency");
    for (int r = 0; r < 4; r++) begin
      send_range(tbl[r].beats, 0, tbl[r].beats, tbl[r].base, tbl[r].last_keep, 1'b1);
      wait_drain();
      sent_exp = tbl[r].exp_sent;
      chk("table_sent", 64'(sent), 64'(tbl[r].exp_sent));
    end

    rnd_ready = 1'b1;
    for (int p = 0; p < 100; p++) begin
      send_range($urandom_range(1, 6), 0, 6, {$urandom, $urandom}, 8'($urandom_range(1, 255)), 1'b1);
    end
    rnd_ready = 1'b0;
    m_if.tready = 1'b1;
    wait_drain();
    sent_exp += 100;
    chk("backpressure_sent", 64'(sent), 64'(sent_exp));

    send_range(8, 0, 3, 64'h5555_0000, 8'hFF, 1'b1);
    link = 1'b0;
    ab.d = '0; ab.k = '1; ab.l = 1'b1; ab.u = 1'b1;
    exp_q.push_back(ab);
    cyc(SFF + 2);
    send_range(8, 3, 8, 64'h5555_0000, 8'hFF, 1'b0);
    abort_exp++;
    drop_exp++;
    wait_drain();
    chk("loss_abort_count", 64'(abrt), 64'(abort_exp));
    chk("loss_drop_count", 64'(drop), 64'(drop_exp));
    chk("loss_sent_count", 64'(sent), 64'(sent_exp));
    chk("loss_link_ready", 64'(lr), 0);

    send_range(6, 0, 2, 64'h6666_0000, 8'hFF, 1'b0);
    link = 1'b1;
    cyc(SFF + SETTLE + 6);
    chk("settle_holds_mid_pkt", 64'(lr), 0);
    send_range(6, 2, 6, 64'h6666_0000, 8'hFF, 1'b0);
    drop_exp++;
    cyc(2);
    chk("settle_exit", 64'(lr), 1);
    send_range(3, 0, 3, 64'h7777_0000, 8'h3F, 1'b1);
    sent_exp++;
    wait_drain();
    chk("settle_drop_count", 64'(drop), 64'(drop_exp));
    chk("settle_sent_count", 64'(sent), 64'(sent_exp));

    m_if.tready = 1'b0;
    send_beat(64'h8888_0000, 8'hFF, 1'b0);
    cyc(1);
    chk("pre_reset_tvalid", 64'(m_if.tvalid), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_tvalid", 64'(m_if.tvalid), 0);
    chk("arst_tdata", m_if.tdata, 0);
    chk("arst_tkeep_tlast", {m_if.tkeep, m_if.tlast, m_if.tuser}, 0);
    chk("arst_tready", 64'(s_if.tready), 0);
    chk("arst_link_ready", 64'(lr), 0);
    chk("arst_counts", 64'(sent) | 64'(abrt) | 64'(drop), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_if.tready = 1'b1;
    wait_ready("rerun_latency");
    send_range(2, 0, 2, 64'h9999_0000, 8'h07, 1'b1);
    wait_drain();
    chk("rerun_sent", 64'(sent), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/cmac_tx_gate.md
# cmac_tx_gate

Packet-aware gate between the user transmit AXI-Stream and the CMAC `axis_tx` port, in the `tx_clk` domain. It forwards packets only while PCS alignment is up and stable. If alignment is lost mid-packet, it terminates the in-flight packet with an error-marked final beat so the CMAC never sees a truncated frame. It is the transmit-side companion to the CMAC RX alignment/reset controller and consumes that block's `sync_rx_aligned` output.

## Interface
- `DATA_W`, 512: tdata width; tkeep is `DATA_W/8`.
- `SYNC_FF`, 3: synchronizer stages applied to `link_aligned`, range 2..8.
- `LINK_SETTLE`, 1024: `tx_clk` cycles alignment must stay high before traffic is admitted; 0 is legal.
- `DROP_WHEN_DOWN`, 1: 1 = discard input packets while the link is down; 0 = backpressure.
- `tx_clk`  in  1  CMAC transmit user clock; all logic is on its rising edge.
- `tx_reset_in`  in  1  reset, asynchronous, active-high.
- `link_aligned`  in  1  PCS alignment, asynchronous to `tx_clk`.
- `s_axis_tdata/tkeep/tlast/tvalid/tready`  in/in/in/in/out  DATA_W/DATA_W/8/1/1/1  user transmit stream.
- `m_axis_tdata/tkeep/tlast/tuser/tvalid/tready`  out/out/out/out/out/in  DATA_W/DATA_W/8/1/1/1/1  to CMAC `axis_tx`; tuser=1 marks a bad frame.
- `link_ready`  out  1  high in IDLE or PKT.
- `pkt_sent_count`, `pkt_abort_count`, `pkt_drop_count`  out  32 each  wrapping event counters.

## Operation
- `sl` is `link_aligned` after `SYNC_FF` flops (reset 0).
- Output is a single register stage. A slot is free when `!m_axis_tvalid || m_axis_tready`.
- `in_pkt` flag: set on an accepted beat with tlast=0; cleared on an accepted beat with tlast=1.
- States:
  - DOWN:
    - tready = `DROP_WHEN_DOWN`; accepted beats are discarded.
    - When `sl`=1, go to SETTLE and load the settle counter with `LINK_SETTLE`.
  - SETTLE:
    - tready = `DROP_WHEN_DOWN`; beats are discarded.
    - If `sl`=0, go to DOWN.
    - Otherwise the counter decrements to 0. Go to IDLE when the counter is 0 and `in_pkt`=0, so a packet is never entered mid-way.
  - IDLE:
    - tready = slot free. An accepted beat loads the output register with tuser=0.
    - If tlast=0, go to PKT.
    - If `sl`=0, go to DOWN with tready forced 0 that cycle.
  - PKT:
    - Same forwarding as IDLE. Accepting the tlast beat returns to IDLE.
    - If `sl`=0, tready is forced 0, no beat is accepted, and the state goes to ABORT.
  - ABORT:
    - tready=0. When the slot is free, load the abort beat: tdata=0, tkeep all-ones, tlast=1, tuser=1.
    - Then go to DISCARD.
  - DISCARD:
    - tready=1. Consume input until an accepted tlast beat, then go to DOWN.
- Counters:
  - `pkt_sent_count` +1 on each output handshake with tlast=1 and tuser=0.
  - `pkt_abort_count` +1 when the abort beat is loaded.
  - `pkt_drop_count` +1 on each accepted tlast beat that is discarded in DOWN, SETTLE or DISCARD.
  - All counters wrap modulo 2^32.
- `m_axis_tvalid` is never dropped without a handshake, and the register contents are stable while stalled.

## Timing
- Reset values: state DOWN; `m_axis_tvalid`=0, tdata/tkeep/tlast/tuser=0; `s_axis_tready`=0 (combinational from state); `link_ready`=0; counters=0; `in_pkt`=0; settle counter=0.
- Reset may assert mid-packet. The output register is cleared immediately; the downstream CMAC is reset alongside.
- `link_aligned` rise → `sl` rise: `SYNC_FF` cycles. DOWN→SETTLE is 1 further cycle. SETTLE→IDLE takes `LINK_SETTLE`+1 cycles if input is idle.
- Forwarding latency: s→m beat is 1 cycle. Full throughput of one beat per cycle while `m_axis_tready`=1.
- Link loss in PKT: the abort beat appears on `m_axis` within 1 cycle of the slot freeing.
- Simultaneous events:
  - `sl` falls in the same cycle as a tlast beat is offered in PKT: loss wins and the beat is not accepted, so an abort occurs.
  - `sl` falls in IDLE with no packet open: no abort.
  - `sl` returns high during ABORT or DISCARD: ignored until DOWN is reached.

## Test plan
- Bring-up: `LINK_SETTLE`=16, raise `link_aligned`, send a 4-beat packet → `link_ready` rises `SYNC_FF`+18 cycles later; 4 beats out unchanged with tuser=0; `pkt_sent_count`=1.
- Backpressure: random `m_axis_tready` at 50% across 100 packets → output byte stream equals input; tvalid never withdrawn without a handshake; `pkt_sent_count`=100.
- Mid-packet loss: drop `link_aligned` after beat 3 of 8 → 3 beats out, then one beat with tlast=1, tuser=1, tdata=0; the remaining 5 input beats are consumed; `pkt_abort_count`=1 and `pkt_drop_count`=1.
- Down with `DROP_WHEN_DOWN`=1: send 5 packets with the link low → tready=1, no `m_axis_tvalid`, `pkt_drop_count`=5. With `DROP_WHEN_DOWN`=0, tready stays 0.
- Link rises mid-input-packet in SETTLE → that packet is fully discarded; the next packet is forwarded intact starting at its first beat.
- Async reset asserted mid-packet with `m_axis_tvalid`=1 → all outputs are at reset values in the same cycle; the state restarts from DOWN.
